// File: rtl/demux_scan_pkg.sv
// Shared types and sizes for the demux scan sequencer.
// Channel count, select width and FSM state encoding.
package demux_scan_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/demux_scan_next.sv
// Next-channel search: lowest set mask bit above ch,
// or the lowest set bit overall when first is high.
module demux_scan_next
  import demux_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] ch,
  input  logic            first,
  output logic [SELW-1:0] nxt,
  output logic            found
);

  // Descending walk so the lowest qualifying bit wins
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(ch)))) begin
        nxt   = SELW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer driving sel/d of a 1-to-16 demux.
// Walks enabled channels: DWELL cycles routed, GAP cycles low.
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [NCH-1:0]  mask,
  input  logic            din,
  output logic [SELW-1:0] sel,
  output logic            d,
  output logic            valid,
  output logic            busy,
  output logic            done
);

  localparam logic [7:0] DW_LD = 8'(DWELL - 1);
  localparam logic [7:0] GP_LD = 8'(GAP - 1);

  state_t          state;
  logic [NCH-1:0]  mask_q;
  logic [SELW-1:0] ch;
  logic [7:0]      cnt;

  logic [NCH-1:0]  srch_mask;
  logic            srch_first;
  logic [SELW-1:0] nxt;
  logic            found;

  // IDLE searches the live mask from bit 0, otherwise above ch
  always_comb begin
    srch_first = (state == ST_IDLE);
    srch_mask  = srch_first ? mask : mask_q;
  end

  demux_scan_next u_next (
    .mask  (srch_mask),
    .ch    (ch),
    .first (srch_first),
    .nxt   (nxt),
    .found (found)
  );

  // Scan FSM with counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mask_q <= '0;
      ch     <= '0;
      cnt    <= '0;
      sel    <= '0;
      d      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            mask_q <= mask;
            busy   <= 1'b1;
            if (found) begin
              ch    <= nxt;
              sel   <= nxt;
              cnt   <= DW_LD;
              valid <= 1'b1;
              d     <= din;
              state <= ST_DRIVE;
            end else begin
              done  <= 1'b1;
              d     <= 1'b0;
              state <= ST_DONE;
            end
          end
        end
        ST_DRIVE: begin
          if (stop) begin
            state <= ST_IDLE;
            d     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == 8'd0) begin
            cnt   <= GP_LD;
            d     <= 1'b0;
            valid <= 1'b0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - 8'd1;
            d   <= din;
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            d     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (found) begin
            ch    <= nxt;
            sel   <= nxt;
            cnt   <= DW_LD;
            valid <= 1'b1;
            d     <= din;
            state <= ST_DRIVE;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          d     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Randomized bench for demux_scan_ctrl.
// Expected waveforms come from a per-scan schedule model.
module tb_demux_scan_ctrl;

  localparam int DW  = 4;
  localparam int GP  = 1;
  localparam int PER = DW + GP;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] mask;
  logic        din;
  logic [3:0]  sel;
  logic        d;
  logic        valid;
  logic        busy;
  logic        done;

  int npass;
  int ntot;
  logic [3:0] xsel;

  demux_scan_ctrl #(.DWELL(DW), .GAP(GP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .mask  (mask),
    .din   (din),
    .sel   (sel),
    .d     (d),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string got();
    return $sformatf("sel=%0d valid=%b d=%b busy=%b done=%b",
                     sel, valid, d, busy, done);
  endfunction

  function automatic string want(logic [3:0] s, logic v,
                                 logic dd, logic b, logic dn);
    return $sformatf("sel=%0d valid=%b d=%b busy=%b done=%b",
                     s, v, dd, b, dn);
  endfunction

  // Cycle j after the start cycle: channel list, dwell then gap
  // per channel, one done cycle, then idle holding last sel.
  function automatic void model(
    input  logic [15:0] m,
    input  int          j,
    input  logic        dp,
    input  logic [3:0]  s0,
    output logic [3:0]  es,
    output logic        ev,
    output logic        ed,
    output logic        eb,
    output logic        edn
  );
    int n;
    int chs[16];
    int p;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      chs[i] = 0;
      if (m[i]) begin
        chs[n] = i;
        n++;
      end
    end
    p   = j - 1;
    es  = s0;
    ev  = 1'b0;
    ed  = 1'b0;
    eb  = 1'b0;
    edn = 1'b0;
    if (p < n * PER) begin
      es = 4'(chs[p / PER]);
      ev = (p % PER) < DW;
      ed = ev & dp;
      eb = 1'b1;
    end else begin
      if (n > 0) es = 4'(chs[n - 1]);
      if (p == n * PER) begin
        eb  = 1'b1;
        edn = 1'b1;
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mask  = 16'h0;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    ntot++;
    if ({sel, valid, d, busy, done} !== 8'h0)
      $display("FAIL reset_state got %s want all 0", got());
    else npass++;
    rst_n = 1'b1;
    xsel  = 4'd0;
    @(negedge clk);
    ntot++;
    if ({sel, valid, d, busy, done} !== 8'h0)
      $display("FAIL reset_release got %s want all 0", got());
    else npass++;
  endtask

  task automatic test_full_scan();
    logic [3:0] es;
    logic ev, ed, eb, edn, dp;
    int dn_at;
    tick();
    start = 1'b1;
    stop  = 1'b0;
    mask  = 16'hFFFF;
    din   = 1'b1;
    dp    = din;
    dn_at = -1;
    for (int j = 1; j <= 16 * PER + 1; j++) begin
      tick();
      start = 1'b0;
      mask  = 16'($urandom);
      din   = 1'b1;
      @(negedge clk);
      model(16'hFFFF, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL full_scan j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      if (done && dn_at < 0) dn_at = j;
      xsel = es;
      dp   = din;
    end
    ntot++;
    if (dn_at != 81)
      $display("FAIL full_done_time got %0d want 81", dn_at);
    else npass++;
  endtask

  task automatic test_sparse();
    logic [3:0] es;
    logic ev, ed, eb, edn, dp;
    int dn_at;
    tick();
    start = 1'b1;
    mask  = 16'h8421;
    din   = 1'($urandom);
    dp    = din;
    dn_at = -1;
    for (int j = 1; j <= 4 * PER + 1; j++) begin
      tick();
      start = 1'b0;
      din   = 1'($urandom);
      @(negedge clk);
      model(16'h8421, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL sparse j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      if (done && dn_at < 0) dn_at = j;
      xsel = es;
      dp   = din;
    end
    ntot++;
    if (dn_at != 21)
      $display("FAIL sparse_done_time got %0d want 21", dn_at);
    else npass++;
  endtask

  task automatic test_zero_mask();
    logic [3:0] es;
    logic ev, ed, eb, edn;
    tick();
    start = 1'b1;
    mask  = 16'h0;
    din   = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      model(16'h0, j, 1'b1, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL zero_mask j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
    end
  endtask

  task automatic test_abort();
    logic [3:0] es;
    logic ev, ed, eb, edn, dp;
    tick();
    start = 1'b1;
    mask  = 16'hFFFF;
    din   = 1'($urandom);
    dp    = din;
    for (int j = 1; j <= 17; j++) begin
      tick();
      start = 1'b0;
      stop  = (j == 17);
      din   = 1'($urandom);
      @(negedge clk);
      model(16'hFFFF, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL abort_pre j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      xsel = es;
      dp   = din;
    end
    tick();
    stop  = 1'b0;
    start = 1'b1;
    mask  = 16'h0012;
    din   = 1'($urandom);
    @(negedge clk);
    ntot++;
    if ({sel, valid, d, busy, done} !== {4'd3, 4'b0000})
      $display("FAIL abort_idle got %s want %s",
               got(), want(4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    else npass++;
    xsel = 4'd3;
    dp   = din;
    for (int j = 1; j <= 2 * PER + 1; j++) begin
      tick();
      start = 1'b0;
      din   = 1'($urandom);
      @(negedge clk);
      model(16'h0012, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL abort_restart j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      xsel = es;
      dp   = din;
    end
  endtask

  task automatic test_start_stop();
    tick();
    start = 1'b1;
    stop  = 1'b1;
    mask  = 16'hFFFF;
    for (int j = 1; j <= 2; j++) begin
      tick();
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      ntot++;
      if ({sel, valid, d, busy, done} !== {xsel, 4'b0000})
        $display("FAIL start_stop j=%0d got %s want %s",
                 j, got(), want(xsel, 1'b0, 1'b0, 1'b0, 1'b0));
      else npass++;
    end
  endtask

  task automatic test_random_back_to_back();
    logic [3:0] es;
    logic ev, ed, eb, edn, dp;
    logic [15:0] m;
    int n;
    for (int s = 0; s < 6; s++) begin
      if (s == 0) m = 16'h8000;
      else if (s == 1) m = 16'h0;
      else m = 16'($urandom) & 16'($urandom);
      n = $countones(m);
      tick();
      start = 1'b1;
      mask  = m;
      din   = 1'($urandom);
      dp    = din;
      @(negedge clk);
      ntot++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL b2b_idle s=%0d got %s want busy=0 done=0",
                 s, got());
      else npass++;
      for (int j = 1; j <= n * PER + 1; j++) begin
        tick();
        start = ($urandom_range(3) == 0);
        mask  = 16'($urandom);
        din   = 1'($urandom);
        @(negedge clk);
        model(m, j, dp, xsel, es, ev, ed, eb, edn);
        ntot++;
        if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
          $display("FAIL random s=%0d m=%h j=%0d got %s want %s",
                   s, m, j, got(), want(es, ev, ed, eb, edn));
        else npass++;
        xsel = es;
        dp   = din;
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] es;
    logic ev, ed, eb, edn, dp;
    tick();
    start = 1'b1;
    mask  = 16'hFFFF;
    din   = 1'b1;
    dp    = din;
    for (int j = 1; j <= 40; j++) begin
      tick();
      start = 1'b0;
      din   = 1'($urandom);
      @(negedge clk);
      model(16'hFFFF, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL rst_pre j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      xsel = es;
      dp   = din;
    end
    rst_n = 1'b0;
    #1;
    ntot++;
    if ({sel, valid, d, busy, done} !== 8'h0)
      $display("FAIL rst_async got %s want all 0", got());
    else npass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xsel  = 4'd0;
    tick();
    start = 1'b1;
    mask  = 16'h0080;
    din   = 1'($urandom);
    dp    = din;
    for (int j = 1; j <= PER + 2; j++) begin
      tick();
      start = 1'b0;
      din   = 1'($urandom);
      @(negedge clk);
      model(16'h0080, j, dp, xsel, es, ev, ed, eb, edn);
      ntot++;
      if ({sel, valid, d, busy, done} !== {es, ev, ed, eb, edn})
        $display("FAIL rst_rescan j=%0d got %s want %s",
                 j, got(), want(es, ev, ed, eb, edn));
      else npass++;
      xsel = es;
      dp   = din;
    end
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    xsel  = 4'd0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_zero_mask();
    test_abort();
    test_start_stop();
    test_random_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
